rv32i_core: RTL and testbench

//  Single-cycle RV32I processor, top-level compute block of the FPGA design. Fetches from an internal

---
 rtl/rv32i_pkg.sv | 85 ++++++++
 rtl/bios_ram.sv | 27 ++
 rtl/reg_file.sv | 23 ++
 rtl/rv32i_core.sv | 225 ++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode/funct constants, decode enums and immediate helper
package rv32i_pkg;

   localparam logic [31:0] RESET_PC   = 32'h4000_0000;

   localparam logic [6:0]  OP_LUI     = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC   = 7'b0010111;
   localparam logic [6:0]  OP_JAL     = 7'b1101111;
   localparam logic [6:0]  OP_JALR    = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
   localparam logic [6:0]  OP_LOAD    = 7'b0000011;
   localparam logic [6:0]  OP_STORE   = 7'b0100011;
   localparam logic [6:0]  OP_IMM     = 7'b0010011;
   localparam logic [6:0]  OP_REG     = 7'b0110011;
   localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;

   localparam logic [2:0]  F3_ADD     = 3'd0;
   localparam logic [2:0]  F3_SLL     = 3'd1;
   localparam logic [2:0]  F3_SLT     = 3'd2;
   localparam logic [2:0]  F3_SLTU    = 3'd3;
   localparam logic [2:0]  F3_XOR     = 3'd4;
   localparam logic [2:0]  F3_SR      = 3'd5;
   localparam logic [2:0]  F3_OR      = 3'd6;
   localparam logic [2:0]  F3_AND     = 3'd7;

   localparam logic [2:0]  F3_BEQ     = 3'd0;
   localparam logic [2:0]  F3_BNE     = 3'd1;
   localparam logic [2:0]  F3_BLT     = 3'd4;
   localparam logic [2:0]  F3_BGE     = 3'd5;
   localparam logic [2:0]  F3_BLTU    = 3'd6;
   localparam logic [2:0]  F3_BGEU    = 3'd7;

   localparam logic [2:0]  F3_LB      = 3'd0;
   localparam logic [2:0]  F3_LH      = 3'd1;
   localparam logic [2:0]  F3_LW      = 3'd2;
   localparam logic [2:0]  F3_LBU     = 3'd4;
   localparam logic [2:0]  F3_LHU     = 3'd5;

   localparam logic [2:0]  F3_CSRRW   = 3'd1;
   localparam logic [2:0]  F3_CSRRWI  = 3'd5;
   localparam logic [11:0] CSR_TOHOST = 12'h51E;

   localparam logic [6:0]  F7_ALT     = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;

   // Opcode bits [6:0] never carry immediate data, so only [31:7] is passed in
   function automatic logic [31:0] gen_imm(input logic [31:7] instr, input imm_type_e t);
      logic [31:0] imm;
      imm = {{20{instr[31]}}, instr[31:20]};
      case (t)
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'd0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = {{20{instr[31]}}, instr[31:20]};
      endcase
      return imm;
   endfunction

   // alt is funct7[5]; for OP-IMM the caller only forwards it on shift-right
   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bios_ram.sv
// rtl/bios_ram.sv - BIOS word memory: async instruction and data read, byte-lane write
module bios_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] i_iaddr,
   output logic [31:0]   o_idata,
   input  logic [AW-1:0] i_daddr,
   output logic [31:0]   o_ddata,
   input  logic [3:0]    i_we,
   input  logic [31:0]   i_wdata
);

   logic [31:0] mem [0:DEPTH-1];

   assign o_idata = mem[i_iaddr];
   assign o_ddata = mem[i_daddr];

   // Byte-lane store; the read ports see the new word from the following cycle on
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b]) mem[i_daddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
   end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two async read ports, one write port, x0 hardwired to 0
module reg_file (
   input  logic        clk,
   input  logic [4:0]  i_raddr1,
   output logic [31:0] o_rdata1,
   input  logic [4:0]  i_raddr2,
   output logic [31:0] o_rdata2,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata
);

   logic [31:0] mem [0:31];

   assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : mem[i_raddr1];
   assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : mem[i_raddr2];

   // Write port; writes to x0 are dropped so mem[0] is never disturbed
   always_ff @(posedge clk) begin
      if (i_we && (i_waddr != 5'd0)) mem[i_waddr] <= i_wdata;
   end

endmodule

// File: rtl/rv32i_core.sv
// rtl/rv32i_core.sv - single-cycle RV32I core with BIOS memory; CSR_TOHOST_EN adds the tohost CSR
module rv32i_core #(
   parameter int          CPU_CLOCK_FREQ = 50_000_000,
   parameter logic [31:0] RESET_PC       = 32'h4000_0000,
   parameter int          BIOS_DEPTH     = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic bp_enable,
   input  logic serial_in,
   output logic serial_out
);
   import rv32i_pkg::*;

   localparam int BIOS_AW = $clog2(BIOS_DEPTH);

   logic [31:0] r_pc;
   logic [31:0] w_instr, w_imm, w_pc4, w_pc_imm, w_next_pc;
   logic [31:0] w_rs1_val, w_rs2_val, w_alu_a, w_alu_b, w_alu_res;
   logic [31:0] w_dword, w_load_val, w_st_data, w_rf_wdata, w_csr_rdata;
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [3:0]  w_st_be;
   logic        w_alu_a_pc, w_alu_b_imm, w_rf_we, w_is_store, w_is_branch;
   logic        w_is_jal, w_is_jalr, w_br_taken, w_in_bios, w_csr_we;
   alu_op_e     w_alu_op;
   imm_type_e   w_imm_type;
   wb_sel_e     w_wb_sel;
   logic        w_unused;

   assign serial_out = 1'b1;
   assign w_unused   = &{1'b0, bp_enable, serial_in, CPU_CLOCK_FREQ[0]};

   assign w_opcode = w_instr[6:0];
   assign w_rd     = w_instr[11:7];
   assign w_f3     = w_instr[14:12];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];
   assign w_imm    = gen_imm(w_instr[31:7], w_imm_type);
   assign w_pc4    = r_pc + 32'd4;
   assign w_pc_imm = r_pc + w_imm;

   reg_file rf (
      .clk      (clk),
      .i_raddr1 (w_rs1),
      .o_rdata1 (w_rs1_val),
      .i_raddr2 (w_rs2),
      .o_rdata2 (w_rs2_val),
      .i_we     (w_rf_we && !rst),
      .i_waddr  (w_rd),
      .i_wdata  (w_rf_wdata)
   );

   bios_ram #(.DEPTH(BIOS_DEPTH), .AW(BIOS_AW)) bios_mem (
      .clk     (clk),
      .i_iaddr (r_pc[BIOS_AW+1:2]),
      .o_idata (w_instr),
      .i_daddr (w_alu_res[BIOS_AW+1:2]),
      .o_ddata (w_dword),
      .i_we    (w_st_be),
      .i_wdata (w_st_data)
   );

   // Control decode: operand selects, immediate format, writeback source
   always_comb begin
      w_alu_op    = ALU_ADD;
      w_imm_type  = IMM_I;
      w_alu_a_pc  = 1'b0;
      w_alu_b_imm = 1'b1;
      w_rf_we     = 1'b0;
      w_wb_sel    = WB_ALU;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;
      w_csr_we    = 1'b0;
      case (w_opcode)
         OP_LUI:    begin w_imm_type = IMM_U; w_alu_op = ALU_PASSB; w_rf_we = 1'b1; end
         OP_AUIPC:  begin w_imm_type = IMM_U; w_alu_a_pc = 1'b1; w_rf_we = 1'b1; end
         OP_JAL:    begin w_imm_type = IMM_J; w_is_jal = 1'b1; w_rf_we = 1'b1; w_wb_sel = WB_PC4; end
         OP_JALR:   begin w_is_jalr = 1'b1; w_rf_we = 1'b1; w_wb_sel = WB_PC4; end
         OP_BRANCH: begin w_imm_type = IMM_B; w_is_branch = 1'b1; end
         OP_LOAD:   begin w_rf_we = 1'b1; w_wb_sel = WB_MEM; end
         OP_STORE:  begin w_imm_type = IMM_S; w_is_store = 1'b1; end
         OP_IMM:    begin
            w_rf_we  = 1'b1;
            w_alu_op = alu_decode(w_f3, (w_f3 == F3_SR) && w_instr[30]);
         end
         OP_REG:    begin
            w_rf_we     = 1'b1;
            w_alu_b_imm = 1'b0;
            w_alu_op    = alu_decode(w_f3, w_instr[30]);
         end
`ifdef CSR_TOHOST_EN
         OP_SYSTEM: begin
            if (((w_f3 == F3_CSRRW) || (w_f3 == F3_CSRRWI)) && (w_instr[31:20] == CSR_TOHOST)) begin
               w_rf_we  = 1'b1;
               w_wb_sel = WB_CSR;
               w_csr_we = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   assign w_alu_a = w_alu_a_pc  ? r_pc  : w_rs1_val;
   assign w_alu_b = w_alu_b_imm ? w_imm : w_rs2_val;

   // ALU: 32-bit wrap-around arithmetic, shifts use the low 5 bits of operand b
   always_comb begin
      w_alu_res = w_alu_a + w_alu_b;
      case (w_alu_op)
         ALU_SUB:   w_alu_res = w_alu_a - w_alu_b;
         ALU_SLL:   w_alu_res = w_alu_a << w_alu_b[4:0];
         ALU_SLT:   w_alu_res = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
         ALU_SLTU:  w_alu_res = {31'd0, w_alu_a < w_alu_b};
         ALU_XOR:   w_alu_res = w_alu_a ^ w_alu_b;
         ALU_SRL:   w_alu_res = w_alu_a >> w_alu_b[4:0];
         ALU_SRA:   w_alu_res = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
         ALU_OR:    w_alu_res = w_alu_a | w_alu_b;
         ALU_AND:   w_alu_res = w_alu_a & w_alu_b;
         ALU_PASSB: w_alu_res = w_alu_b;
         default:   w_alu_res = w_alu_a + w_alu_b;
      endcase
   end

   // Branch condition from the two register operands
   always_comb begin
      w_br_taken = 1'b0;
      case (w_f3)
         F3_BEQ:  w_br_taken = (w_rs1_val == w_rs2_val);
         F3_BNE:  w_br_taken = (w_rs1_val != w_rs2_val);
         F3_BLT:  w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
         F3_BGE:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
         F3_BLTU: w_br_taken = (w_rs1_val <  w_rs2_val);
         F3_BGEU: w_br_taken = (w_rs1_val >= w_rs2_val);
         default: w_br_taken = 1'b0;
      endcase
   end

   // Next PC: sequential, PC-relative jump/branch, or register jump with bit 0 cleared
   always_comb begin
      w_next_pc = w_pc4;
      if (w_is_jal || (w_is_branch && w_br_taken)) w_next_pc = w_pc_imm;
      if (w_is_jalr) w_next_pc = {w_alu_res[31:1], 1'b0};
   end

   assign w_in_bios = (w_alu_res[31:28] == 4'h4);

   // Store lanes: low address bits pick the lane; misaligned halves/words fall back to aligned
   always_comb begin
      w_st_be   = 4'b0000;
      w_st_data = w_rs2_val;
      if (w_is_store && w_in_bios && !rst) begin
         case (w_f3[1:0])
            2'b00: begin
               w_st_be   = 4'b0001 << w_alu_res[1:0];
               w_st_data = {4{w_rs2_val[7:0]}};
            end
            2'b01: begin
               w_st_be   = w_alu_res[1] ? 4'b1100 : 4'b0011;
               w_st_data = {2{w_rs2_val[15:0]}};
            end
            default: w_st_be = 4'b1111;
         endcase
      end
   end

   // Load extraction and extension; anything outside the BIOS window reads as 0
   always_comb begin
      case (w_alu_res[1:0])
         2'd0:    w_ld_byte = w_dword[7:0];
         2'd1:    w_ld_byte = w_dword[15:8];
         2'd2:    w_ld_byte = w_dword[23:16];
         default: w_ld_byte = w_dword[31:24];
      endcase
      w_ld_half  = w_alu_res[1] ? w_dword[31:16] : w_dword[15:0];
      w_load_val = 32'd0;
      if (w_in_bios) begin
         case (w_f3)
            F3_LB:   w_load_val = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_LH:   w_load_val = {{16{w_ld_half[15]}}, w_ld_half};
            F3_LBU:  w_load_val = {24'd0, w_ld_byte};
            F3_LHU:  w_load_val = {16'd0, w_ld_half};
            default: w_load_val = w_dword;
         endcase
      end
   end

`ifdef CSR_TOHOST_EN
   logic [31:0] r_tohost;

   assign w_csr_rdata = r_tohost;

   // tohost CSR: cleared by reset, replaced by CSRRW (rs1 value) or CSRRWI (zero-extended rs1 field)
   always_ff @(posedge clk) begin
      if (rst) r_tohost <= 32'd0;
      else if (w_csr_we) r_tohost <= w_f3[2] ? {27'd0, w_rs1} : w_rs1_val;
   end
`else
   assign w_csr_rdata = 32'd0;
`endif

   // Writeback source select
   always_comb begin
      w_rf_wdata = w_alu_res;
      case (w_wb_sel)
         WB_MEM:  w_rf_wdata = w_load_val;
         WB_PC4:  w_rf_wdata = w_pc4;
         WB_CSR:  w_rf_wdata = w_csr_rdata;
         default: w_rf_wdata = w_alu_res;
      endcase
   end

   // PC register: reset vector, otherwise one instruction retires per cycle
   always_ff @(posedge clk) begin
      if (rst) r_pc <= RESET_PC;
      else     r_pc <= w_next_pc;
   end

endmodule

// File: tb/tb_rv32i_core.sv
// tb/tb_rv32i_core.sv - directed program tests for rv32i_core
module tb_rv32i_core;

   localparam logic [6:0] OPI  = 7'h13;
   localparam logic [6:0] LUI  = 7'h37;
   localparam logic [6:0] LD   = 7'h03;
   localparam logic [6:0] JALR = 7'h67;

   logic clk = 1'b0;
   logic rst;
   logic bp_enable;
   logic serial_in;
   logic serial_out;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] prog [$];

   rv32i_core dut (
      .clk        (clk),
      .rst        (rst),
      .bp_enable  (bp_enable),
      .serial_in  (serial_in),
      .serial_out (serial_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return enc_i(imm, rs1, 3'd0, rd, OPI);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic boot();
      rst = 1'b1;
      for (int i = 0; i < prog.size(); i++) dut.bios_mem.mem[i] = prog[i];
      tick();
      tick();
      rst = 1'b0;
      prog.delete();
   endtask

   task automatic run_until_flag(input logic [31:0] flag, input string tag);
      int cyc;
      cyc = 0;
      while ((dut.rf.mem[20] !== flag) && (cyc < 100)) begin
         tick();
         cyc++;
      end
      check(tag, dut.rf.mem[20], flag);
   endtask

   initial begin
      rst       = 1'b1;
      bp_enable = 1'b0;
      serial_in = 1'b1;
      for (int i = 0; i < 32; i++) dut.rf.mem[i] = 32'd0;
      tick();
      tick();
      check("reset_pc", dut.r_pc, 32'h4000_0000);
      check("serial_out_in_reset", {31'd0, serial_out}, 32'd1);

      // Program 1: add chain, first-instruction latency
      prog.push_back(addi(5'd1, 5'd0, 12'd100));
      prog.push_back(addi(5'd2, 5'd0, 12'd200));
      prog.push_back(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd1));
      prog.push_back(addi(5'd20, 5'd0, 12'd1));
      prog.push_back(enc_j(21'd0, 5'd0));
      boot();
      tick();
      check("first_instr_x1", dut.rf.mem[1], 32'd100);
      check("first_instr_pc", dut.r_pc, 32'h4000_0004);
      run_until_flag(32'd1, "p1_flag");
      check("p1_x1", dut.rf.mem[1], 32'd300);
      check("p1_x2", dut.rf.mem[2], 32'd200);

      // Program 2: taken beq, not-taken bgeu, taken blt
      bp_enable = 1'b1;
      prog.push_back(addi(5'd1, 5'd0, 12'd500));
      prog.push_back(addi(5'd2, 5'd0, 12'd100));
      prog.push_back(enc_b(13'd8, 5'd1, 5'd1, 3'd0));
      prog.push_back(addi(5'd1, 5'd0, 12'd999));
      prog.push_back(enc_b(13'd8, 5'd1, 5'd2, 3'd7));
      prog.push_back(enc_b(13'd8, 5'd1, 5'd2, 3'd4));
      prog.push_back(addi(5'd2, 5'd0, 12'd777));
      prog.push_back(addi(5'd20, 5'd0, 12'd2));
      prog.push_back(enc_j(21'd0, 5'd0));
      boot();
      run_until_flag(32'd2, "p2_flag");
      check("p2_x1", dut.rf.mem[1], 32'd500);
      check("p2_x2", dut.rf.mem[2], 32'd100);
      bp_enable = 1'b0;

      // Program 3: lui/addi constants and bitwise ops
      prog.push_back(enc_u(20'hFF010, 5'd1, LUI));
      prog.push_back(addi(5'd1, 5'd1, 12'hF00));
      prog.push_back(enc_u(20'h0F0F1, 5'd2, LUI));
      prog.push_back(addi(5'd2, 5'd2, 12'hF0F));
      prog.push_back(enc_r(7'd0, 5'd2, 5'd1, 3'd7, 5'd14));
      prog.push_back(enc_r(7'd0, 5'd2, 5'd1, 3'd6, 5'd15));
      prog.push_back(enc_r(7'd0, 5'd2, 5'd1, 3'd4, 5'd16));
      prog.push_back(addi(5'd20, 5'd0, 12'd3));
      prog.push_back(enc_j(21'd0, 5'd0));
      boot();
      run_until_flag(32'd3, "p3_flag");
      check("p3_x1", dut.rf.mem[1], 32'hFF00_FF00);
      check("p3_and", dut.rf.mem[14], 32'h0F00_0F00);
      check("p3_or", dut.rf.mem[15], 32'hFF0F_FF0F);
      check("p3_xor", dut.rf.mem[16], 32'hF00F_F00F);

      // Program 4: loads/stores, sub-word lanes, shifts, compares
      prog.push_back(enc_u(20'h40001, 5'd3, LUI));
      prog.push_back(enc_u(20'hDEADC, 5'd4, LUI));
      prog.push_back(addi(5'd4, 5'd4, 12'hEEF));
      prog.push_back(enc_s(12'd0, 5'd4, 5'd3, 3'd2));
      prog.push_back(enc_i(12'd3, 5'd3, 3'd0, 5'd5, LD));
      prog.push_back(enc_i(12'd3, 5'd3, 3'd4, 5'd6, LD));
      prog.push_back(enc_i(12'd2, 5'd3, 3'd1, 5'd7, LD));
      prog.push_back(enc_i(12'd0, 5'd3, 3'd5, 5'd8, LD));
      prog.push_back(addi(5'd9, 5'd0, 12'h055));
      prog.push_back(enc_s(12'd1, 5'd9, 5'd3, 3'd0));
      prog.push_back(enc_i(12'd0, 5'd3, 3'd2, 5'd10, LD));
      prog.push_back(enc_s(12'd2, 5'd9, 5'd3, 3'd1));
      prog.push_back(enc_i(12'd0, 5'd3, 3'd2, 5'd11, LD));
      prog.push_back(addi(5'd12, 5'd0, 12'hFF0));
      prog.push_back(enc_i(12'h404, 5'd12, 3'd5, 5'd13, OPI));
      prog.push_back(addi(5'd17, 5'd0, 12'd1));
      prog.push_back(enc_r(7'd0, 5'd17, 5'd13, 3'd2, 5'd18));
      prog.push_back(enc_r(7'd0, 5'd17, 5'd13, 3'd3, 5'd19));
      prog.push_back(enc_r(7'h20, 5'd12, 5'd17, 3'd0, 5'd21));
      prog.push_back(addi(5'd23, 5'd0, 12'd33));
      prog.push_back(enc_r(7'd0, 5'd23, 5'd17, 3'd1, 5'd22));
      prog.push_back(enc_r(7'd0, 5'd17, 5'd13, 3'd5, 5'd24));
      prog.push_back(addi(5'd25, 5'd0, 12'd7));
      prog.push_back(enc_i(12'd0, 5'd0, 3'd2, 5'd25, LD));
      prog.push_back(addi(5'd20, 5'd0, 12'd4));
      prog.push_back(enc_j(21'd0, 5'd0));
      boot();
      run_until_flag(32'd4, "p4_flag");
      check("p4_lb", dut.rf.mem[5], 32'hFFFF_FFDE);
      check("p4_lbu", dut.rf.mem[6], 32'h0000_00DE);
      check("p4_lh", dut.rf.mem[7], 32'hFFFF_DEAD);
      check("p4_lhu", dut.rf.mem[8], 32'h0000_BEEF);
      check("p4_sb_then_lw", dut.rf.mem[10], 32'hDEAD_55EF);
      check("p4_sh_then_lw", dut.rf.mem[11], 32'h0055_55EF);
      check("p4_mem_word", dut.bios_mem.mem[1024], 32'h0055_55EF);
      check("p4_srai", dut.rf.mem[13], 32'hFFFF_FFFF);
      check("p4_slt", dut.rf.mem[18], 32'd1);
      check("p4_sltu", dut.rf.mem[19], 32'd0);
      check("p4_sub", dut.rf.mem[21], 32'd17);
      check("p4_sll_mod32", dut.rf.mem[22], 32'd2);
      check("p4_srl", dut.rf.mem[24], 32'h7FFF_FFFF);
      check("p4_unmapped_load", dut.rf.mem[25], 32'd0);

      // Program 5: jal call over a skipped slot, jalr return with bit 0 cleared
      prog.push_back(enc_j(21'd16, 5'd1));
      prog.push_back(addi(5'd27, 5'd0, 12'd5));
      prog.push_back(addi(5'd20, 5'd0, 12'd5));
      prog.push_back(enc_j(21'd0, 5'd0));
      prog.push_back(enc_j(21'd8, 5'd0));
      prog.push_back(addi(5'd26, 5'd0, 12'd111));
      prog.push_back(enc_i(12'd1, 5'd1, 3'd0, 5'd5, JALR));
      boot();
      run_until_flag(32'd5, "p5_flag");
      check("p5_jal_link", dut.rf.mem[1], 32'h4000_0004);
      check("p5_jalr_link", dut.rf.mem[5], 32'h4000_001C);
      check("p5_skipped", dut.rf.mem[26], 32'd0);
      check("p5_returned", dut.rf.mem[27], 32'd5);

      // Program 6: x0 write, mid-program reset suppresses the in-flight write
      prog.push_back(enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd0));
      prog.push_back(addi(5'd29, 5'd0, 12'd1));
      prog.push_back(addi(5'd29, 5'd29, 12'd1));
      prog.push_back(enc_j(21'h1FFFFC, 5'd0));
      boot();
      tick();
      check("x0_stays_zero", dut.rf.mem[0], 32'd0);
      tick();
      tick();
      tick();
      check("p6_pc_before_rst", dut.r_pc, 32'h4000_0008);
      check("p6_x29_before_rst", dut.rf.mem[29], 32'd2);
      rst = 1'b1;
      tick();
      check("p6_rst_pc", dut.r_pc, 32'h4000_0000);
      check("p6_rst_suppress", dut.rf.mem[29], 32'd2);
      check("p6_serial_out", {31'd0, serial_out}, 32'd1);
      rst = 1'b0;
      tick();
      check("p6_restart_pc", dut.r_pc, 32'h4000_0004);
      tick();
      check("p6_restart_x29", dut.rf.mem[29], 32'd1);
      check("p6_serial_out_run", {31'd0, serial_out}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
